// File: rtl/task1_driver.sv
// task1_driver: replays a programmed operand table into one task1 instance and stores each result or timeout.
// Define TASK1_DRV_CHECK_EN to add per-entry expected values with a sticky mismatch flag and counter.
module task1_driver #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WIDTH-1:0] wr_a,
  input  logic signed [WIDTH-1:0] wr_b,
  input  logic signed [WIDTH-1:0] wr_c,
  input  logic signed [WIDTH-1:0] wr_d,
`ifdef TASK1_DRV_CHECK_EN
  input  logic signed [WIDTH-1:0] wr_exp,
  output logic                    mismatch,
  output logic [AW:0]             mismatch_cnt,
`endif
  input  logic [AW:0]             num,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    in_val,
  output logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] c,
  output logic signed [WIDTH-1:0] d,
  input  logic signed [WIDTH-1:0] Q,
  input  logic                    out_val,
  input  logic [AW-1:0]           rd_addr,
  output logic signed [WIDTH-1:0] rd_q,
  output logic                    rd_tmo,
  output logic                    tmo_any
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [AW:0]   NUM_MAX  = (AW+1)'(DEPTH);

  // state  | meaning
  // IDLE   | waiting for start, table writable
  // ISSUE  | one-cycle in_val pulse with table[idx]
  // WAIT   | operands held, waiting for out_val or timeout
  // DONE   | one-cycle done pulse, table writable
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [AW:0]            num_q, num_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DEPTH-1:0]       tmo_q, tmo_d;
  logic                   tmo_any_q, tmo_any_d;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic signed [WIDTH-1:0] rd_q_q;
  logic                   rd_tmo_q;

  logic signed [WIDTH-1:0] tbl_a [DEPTH];
  logic signed [WIDTH-1:0] tbl_b [DEPTH];
  logic signed [WIDTH-1:0] tbl_c [DEPTH];
  logic signed [WIDTH-1:0] tbl_d [DEPTH];
  logic signed [WIDTH-1:0] res_mem [DEPTH];

  logic                   wr_acc;
  logic                   res_we;
  logic signed [WIDTH-1:0] res_wdata;
  logic                   ld_en;
  logic [AW-1:0]          ld_idx;
  logic                   adv;
  logic                   last;

`ifdef TASK1_DRV_CHECK_EN
  logic signed [WIDTH-1:0] exp_mem [DEPTH];
  logic                   mis_q, mis_d;
  logic [AW:0]            mcnt_q, mcnt_d;
`endif

  assign wr_acc = wr_en && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      tbl_a[wr_addr] <= wr_a;
      tbl_b[wr_addr] <= wr_b;
      tbl_c[wr_addr] <= wr_c;
      tbl_d[wr_addr] <= wr_d;
`ifdef TASK1_DRV_CHECK_EN
      exp_mem[wr_addr] <= wr_exp;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    tmo_any_d = tmo_any_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    d_d       = d_q;
    res_we    = 1'b0;
    res_wdata = Q;
    ld_en     = 1'b0;
    ld_idx    = idx_q;
    adv       = 1'b0;
    last      = ({1'b0, idx_q} == (num_q - 1'b1));
`ifdef TASK1_DRV_CHECK_EN
    mis_d     = mis_q;
    mcnt_d    = mcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef TASK1_DRV_CHECK_EN
          mis_d  = 1'b0;
          mcnt_d = '0;
`endif
          if (num == '0) begin
            state_d = S_DONE;
          end else begin
            num_d     = (num > NUM_MAX) ? NUM_MAX : num;
            idx_d     = '0;
            tmo_d     = '0;
            tmo_any_d = 1'b0;
            ld_en     = 1'b1;
            ld_idx    = '0;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (out_val) begin
          res_we       = 1'b1;
          res_wdata    = Q;
          tmo_d[idx_q] = 1'b0;
          adv          = 1'b1;
`ifdef TASK1_DRV_CHECK_EN
          if (Q != exp_mem[idx_q]) begin
            mis_d  = 1'b1;
            mcnt_d = mcnt_q + 1'b1;
          end
`endif
        end else if (cnt_q == CNT_LAST) begin
          res_we       = 1'b1;
          res_wdata    = '0;
          tmo_d[idx_q] = 1'b1;
          tmo_any_d    = 1'b1;
          adv          = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (adv) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            ld_en   = 1'b1;
            ld_idx  = idx_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A write landing on the same edge as start must be visible to the first issue.
    if (ld_en) begin
      if (wr_acc && (wr_addr == ld_idx)) begin
        a_d = wr_a;
        b_d = wr_b;
        c_d = wr_c;
        d_d = wr_d;
      end else begin
        a_d = tbl_a[ld_idx];
        b_d = tbl_b[ld_idx];
        c_d = tbl_c[ld_idx];
        d_d = tbl_d[ld_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      tmo_any_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      rd_q_q    <= '0;
      rd_tmo_q  <= 1'b0;
`ifdef TASK1_DRV_CHECK_EN
      mis_q     <= 1'b0;
      mcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      tmo_any_q <= tmo_any_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      d_q       <= d_d;
      rd_q_q    <= res_mem[rd_addr];
      rd_tmo_q  <= tmo_q[rd_addr];
`ifdef TASK1_DRV_CHECK_EN
      mis_q     <= mis_d;
      mcnt_q    <= mcnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst && res_we) begin
      res_mem[idx_q] <= res_wdata;
    end
  end

  assign busy    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done    = (state_q == S_DONE);
  assign in_val  = (state_q == S_ISSUE);
  assign a       = a_q;
  assign b       = b_q;
  assign c       = c_q;
  assign d       = d_q;
  assign rd_q    = rd_q_q;
  assign rd_tmo  = rd_tmo_q;
  assign tmo_any = tmo_any_q;
`ifdef TASK1_DRV_CHECK_EN
  assign mismatch     = mis_q;
  assign mismatch_cnt = mcnt_q;
`endif

endmodule
